complex_square_stage: RTL



---
 rtl/complex_square_stage.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/complex_square_stage.sv
// complex_square_stage: three-stage pipelined w = z^2 + c with sideband and backpressure
module complex_square_stage #(
  parameter int FRAC_BITS = 7,
  parameter int OUT_W     = 10
) (
  input  logic                    out_stream_aclk,
  input  logic                    periph_reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [9:0]       z_re,
  input  logic signed [8:0]       z_im,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic signed [9:0]       c_re,
  input  logic signed [9:0]       c_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] w_re,
  output logic signed [OUT_W-1:0] w_im,
  output logic                    out_first,
  output logic                    out_last
);
  localparam int IW = 22;
  localparam logic signed [IW-1:0] SAT_HI = IW'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [IW-1:0] SAT_LO = ~SAT_HI;

  logic                    w_adv;
  logic                    w_acc;
  logic signed [9:0]       w_beat_c_re;
  logic signed [9:0]       w_beat_c_im;
  logic signed [IW-1:0]    w_rr;
  logic signed [IW-1:0]    w_ii;
  logic signed [IW-1:0]    w_ri;
  logic signed [IW-1:0]    w_re_full;
  logic signed [IW-1:0]    w_im_full;

  logic signed [9:0]       r_c_re;
  logic signed [9:0]       r_c_im;

  logic                    r_s1_v;
  logic signed [9:0]       r_s1_zr;
  logic signed [8:0]       r_s1_zi;
  logic signed [9:0]       r_s1_cr;
  logic signed [9:0]       r_s1_ci;
  logic                    r_s1_first;
  logic                    r_s1_last;

  logic                    r_s2_v;
  logic signed [IW-1:0]    r_s2_rr;
  logic signed [IW-1:0]    r_s2_ii;
  logic signed [IW-1:0]    r_s2_ri;
  logic signed [9:0]       r_s2_cr;
  logic signed [9:0]       r_s2_ci;
  logic                    r_s2_first;
  logic                    r_s2_last;

  logic                    r_s3_v;
  logic signed [OUT_W-1:0] r_s3_re;
  logic signed [OUT_W-1:0] r_s3_im;
  logic                    r_s3_first;
  logic                    r_s3_last;

  function automatic logic signed [OUT_W-1:0] sat(input logic signed [IW-1:0] v);
    return v > SAT_HI ? SAT_HI[OUT_W-1:0] : v < SAT_LO ? SAT_LO[OUT_W-1:0] : v[OUT_W-1:0];
  endfunction

  // Whole pipeline advances together; a first beat uses the live c, later beats the captured c
  always_comb begin
    w_adv       = !r_s3_v || out_ready;
    in_ready    = w_adv && !periph_reset;
    w_acc       = in_valid && in_ready;
    w_beat_c_re = in_first ? c_re : r_c_re;
    w_beat_c_im = in_first ? c_im : r_c_im;
  end

  // Full-precision products of the S1 coordinates, plus the shifted and offset S2 terms
  always_comb begin
    w_rr      = IW'(r_s1_zr) * IW'(r_s1_zr);
    w_ii      = IW'(r_s1_zi) * IW'(r_s1_zi);
    w_ri      = IW'(r_s1_zr) * IW'(r_s1_zi);
    w_re_full = ((r_s2_rr - r_s2_ii) >>> FRAC_BITS) + IW'(r_s2_cr);
    w_im_full = ((r_s2_ri <<< 1) >>> FRAC_BITS) + IW'(r_s2_ci);
  end

  // Frame constant is latched only when a first-of-frame beat is actually accepted
  always_ff @(posedge out_stream_aclk) begin
    if (periph_reset) begin
      r_c_re <= '0;
      r_c_im <= '0;
    end else if (w_acc && in_first) begin
      r_c_re <= c_re;
      r_c_im <= c_im;
    end
  end

  // S1: register the accepted coordinates with the c this beat must use
  always_ff @(posedge out_stream_aclk) begin
    if (periph_reset) begin
      r_s1_v     <= 1'b0;
      r_s1_zr    <= '0;
      r_s1_zi    <= '0;
      r_s1_cr    <= '0;
      r_s1_ci    <= '0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
    end else if (w_adv) begin
      r_s1_v     <= in_valid;
      r_s1_zr    <= z_re;
      r_s1_zi    <= z_im;
      r_s1_cr    <= w_beat_c_re;
      r_s1_ci    <= w_beat_c_im;
      r_s1_first <= in_first;
      r_s1_last  <= in_last;
    end
  end

  // S2: register the three products, carrying c and sideband along
  always_ff @(posedge out_stream_aclk) begin
    if (periph_reset) begin
      r_s2_v     <= 1'b0;
      r_s2_rr    <= '0;
      r_s2_ii    <= '0;
      r_s2_ri    <= '0;
      r_s2_cr    <= '0;
      r_s2_ci    <= '0;
      r_s2_first <= 1'b0;
      r_s2_last  <= 1'b0;
    end else if (w_adv) begin
      r_s2_v     <= r_s1_v;
      r_s2_rr    <= w_rr;
      r_s2_ii    <= w_ii;
      r_s2_ri    <= w_ri;
      r_s2_cr    <= r_s1_cr;
      r_s2_ci    <= r_s1_ci;
      r_s2_first <= r_s1_first;
      r_s2_last  <= r_s1_last;
    end
  end

  // S3: saturated results drive the output port and hold while downstream stalls
  always_ff @(posedge out_stream_aclk) begin
    if (periph_reset) begin
      r_s3_v     <= 1'b0;
      r_s3_re    <= '0;
      r_s3_im    <= '0;
      r_s3_first <= 1'b0;
      r_s3_last  <= 1'b0;
    end else if (w_adv) begin
      r_s3_v     <= r_s2_v;
      r_s3_re    <= sat(w_re_full);
      r_s3_im    <= sat(w_im_full);
      r_s3_first <= r_s2_first;
      r_s3_last  <= r_s2_last;
    end
  end

  assign out_valid = r_s3_v;
  assign w_re      = r_s3_re;
  assign w_im      = r_s3_im;
  assign out_first = r_s3_first;
  assign out_last  = r_s3_last;
endmodule
